// File: rtl/mux_key_internal.sv
// Combinational key compare / priority / select core shared by the mux_key family.
// The lowest-indexed matching pair wins; HAS_DEFAULT=0 yields zero on a miss.
module mux_key_internal #(
  parameter int NR_KEY      = 2,
  parameter int KEY_LEN     = 1,
  parameter int DATA_LEN    = 32,
  parameter bit HAS_DEFAULT = 1'b1
) (
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  out,
  output logic                                 hit
);
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  // Scan from the top pair down so a lower-indexed match overwrites a higher one.
  always_comb begin
    out = HAS_DEFAULT ? default_out : '0;
    hit = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (lut[PAIR_LEN*i + DATA_LEN +: KEY_LEN] == key) begin
        out = lut[PAIR_LEN*i +: DATA_LEN];
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_key_with_default.sv
// Key-lookup multiplexer with default value: combinational result plus a
// registered copy cleared by the asynchronous active-low reset.
module mux_key_with_default #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  out,
  output logic                                 hit,
  output logic [DATA_LEN-1:0]                  out_q,
  output logic                                 hit_q
);
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [NR_KEY*PAIR_LEN-1:0] lut_w;
  assign lut_w = lut;

  mux_key_internal #(
    .NR_KEY     (NR_KEY),
    .KEY_LEN    (KEY_LEN),
    .DATA_LEN   (DATA_LEN),
    .HAS_DEFAULT(1'b1)
  ) u_core (
    .key        (key),
    .default_out(default_out),
    .lut        (lut_w),
    .out        (out),
    .hit        (hit)
  );

  // Only the registered copy is reset; out/hit keep tracking inputs throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= out;
      hit_q <= hit;
    end
  end
endmodule

// File: tb/tb_mux_key_with_default.sv
// Bench for mux_key_with_default: a 2x1x32 read-port instance and a 3x2x8
// instance checked against a forward-scanning first-match reference model.
module tb_mux_key_with_default;
  logic clk;
  logic rst_n;

  // read-port configuration
  logic [0:0]  rp_key;
  logic [31:0] rp_def;
  logic [65:0] rp_lut;
  logic [31:0] rp_out, rp_out_q;
  logic        rp_hit, rp_hit_q;

  // default/priority configuration
  logic [1:0]  key;
  logic [7:0]  def;
  logic [29:0] lut;
  logic [7:0]  out, out_q;
  logic        hit, hit_q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] rp_q[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  prev_exp;
  bit          prev_valid;

  mux_key_with_default #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) u_rp (
    .clk(clk), .rst_n(rst_n), .key(rp_key), .default_out(rp_def), .lut(rp_lut),
    .out(rp_out), .hit(rp_hit), .out_q(rp_out_q), .hit_q(rp_hit_q)
  );

  mux_key_with_default #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .key(key), .default_out(def), .lut(lut),
    .out(out), .hit(hit), .out_q(out_q), .hit_q(hit_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first matching pair scanning upward from pair 0.
  function automatic logic [8:0] model(input logic [1:0] k, input logic [29:0] l,
                                       input logic [7:0] d);
    logic [9:0] pair;
    for (int i = 0; i < 3; i++) begin
      pair = l[10*i +: 10];
      if (pair[9:8] == k) return {1'b1, pair[7:0]};
    end
    return {1'b0, d};
  endfunction

  // Drive at negedge, check comb output, push expected, check registered after edge.
  task automatic rp_cycle(input logic k);
    logic [32:0] e;
    @(negedge clk);
    rp_key = k;
    #1;
    e = (k == 1'b1) ? {1'b1, 32'hDEADBEEF} : {1'b1, 32'h0};
    check("rp_out", rp_out, e[31:0]);
    check("rp_hit", rp_hit, e[32]);
    rp_q.push_back({rp_hit, rp_out});
    @(posedge clk);
    #1;
    e = rp_q.pop_front();
    check("rp_out_q", rp_out_q, e[31:0]);
    check("rp_hit_q", rp_hit_q, e[32]);
  endtask

  task automatic cycle(input logic [1:0] k, input logic [29:0] l, input logic [7:0] d,
                       input string tag);
    logic [8:0] e;
    @(negedge clk);
    key = k; lut = l; def = d;
    #1;
    e = model(k, l, d);
    check({tag, "_out"}, out, e[7:0]);
    check({tag, "_hit"}, hit, e[8]);
    if (prev_valid) check({tag, "_hold"}, {hit_q, out_q}, prev_exp);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_out_q"}, out_q, e[7:0]);
    check({tag, "_hit_q"}, hit_q, e[8]);
    prev_exp   = e;
    prev_valid = 1'b1;
  endtask

  localparam logic [29:0] LUT_DEF = {2'b10, 8'h33, 2'b01, 8'h22, 2'b00, 8'h11};
  localparam logic [29:0] LUT_PRI = {2'b01, 8'h77, 2'b10, 8'h33, 2'b01, 8'h11};

  initial begin
    prev_valid = 1'b0;
    prev_exp   = '0;
    rst_n  = 1'b0;
    rp_key = 1'b0;
    rp_def = 32'h0;
    rp_lut = {1'b0, 32'h0, 1'b1, 32'hDEADBEEF};
    key = 2'b00; def = 8'hA5; lut = LUT_DEF;
    #2;
    check("reset_out_q", out_q, 8'h00);
    check("reset_hit_q", hit_q, 1'b0);
    check("reset_rp_out_q", rp_out_q, 32'h0);
    check("reset_comb_out", out, 8'h11);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // read-port select
    rp_cycle(1'b1);
    rp_cycle(1'b0);
    rp_cycle(1'b1);

    // default path and priority
    cycle(2'b11, LUT_DEF, 8'hA5, "default");
    cycle(2'b10, LUT_DEF, 8'hA5, "match");
    cycle(2'b01, LUT_PRI, 8'hA5, "priority");
    cycle(2'b10, LUT_DEF, 8'hA5, "pre_reset");

    // asynchronous reset mid-cycle
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_out_q", out_q, 8'h00);
    check("async_hit_q", hit_q, 1'b0);
    check("async_out", out, 8'h33);
    check("async_hit", hit, 1'b1);
    @(posedge clk);
    #1;
    check("held_out_q", out_q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_out_q", out_q, 8'h00);
    @(posedge clk);
    #1;
    check("release_out_q_edge", out_q, 8'h33);
    check("release_hit_q_edge", hit_q, 1'b1);
    prev_exp = {1'b1, 8'h33};

    // combinational tracking of default_out
    cycle(2'b11, LUT_DEF, 8'hA5, "track_a5");
    cycle(2'b11, LUT_DEF, 8'h5A, "track_5a");

    // randomised sweep
    for (int n = 0; n < 1000; n++) begin
      cycle(2'($urandom_range(0, 3)), 30'($urandom), 8'($urandom_range(0, 255)), "rand");
    end

    check("queue_empty", 64'(exp_q.size() + rp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_key_with_default.md
Name: mux_key_with_default

Overview:
- Parameterised key-lookup multiplexer.
- Compares a key against NR_KEY (key, data) pairs packed in a flat lookup vector.
- Drives the data of the matching pair, or a supplied default when no pair matches.
- Used throughout the core for decode/select logic, e.g. GPR read-port gating with NR_KEY=2, KEY_LEN=1, DATA_LEN=32.
- Provides a combinational result and a registered copy of that result.

Parameters:
- NR_KEY, 2, number of (key, data) pairs in the lookup vector; must be at least 1.
- KEY_LEN, 1, key width in bits.
- DATA_LEN, 32, data and output width in bits.

Ports:
- clk  input  1  system clock; rising edge used for the registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- key  input  KEY_LEN  lookup key.
- default_out  input  DATA_LEN  value driven when no pair matches.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed lookup pairs.
- out  output  DATA_LEN  combinational lookup result.
- hit  output  1  combinational: at least one pair key equals key.
- out_q  output  DATA_LEN  out registered on clk.
- hit_q  output  1  hit registered on clk.

Behaviour:
- PAIR_LEN = KEY_LEN + DATA_LEN.
- Pair i occupies lut[PAIR_LEN*(i+1)-1 : PAIR_LEN*i].
  - Its key is the upper KEY_LEN bits of that slice; its data is the lower DATA_LEN bits.
  - Pair 0 is the least-significant slice. In a concatenation {k1,d1,k0,d0}, the last-listed pair is pair 0.
- Match: pair i matches when its key is bitwise equal to key. No X/Z or wildcard handling.
- Priority on multiple matches: the lowest-indexed matching pair wins. Duplicate keys are legal and deterministic.
- out: data of the winning pair; default_out when no pair matches.
- hit = 1 iff any pair matches.
- out and hit are purely combinational: zero latency, no latch inferred. They respond within the same cycle to any change of key, lut or default_out.
- out_q and hit_q:
  - Load out and hit on every rising clk edge while rst_n=1; one-cycle latency.
  - No enable, no stall.
- Reset:
  - rst_n=0 asynchronously forces out_q=0 and hit_q=0, independent of clk.
  - Reset affects only the registered outputs; out and hit keep tracking their inputs during reset.
  - Release is synchronous in effect: the first capture occurs on the first rising edge with rst_n=1.
- Boundary cases:
  - NR_KEY=1 degenerates to a single compare.
  - KEY_LEN=1 with both key values listed never selects the default.
  - All outputs are exactly DATA_LEN wide: no truncation and no sign extension.

Decomposition:
- No shared package needed.
- A PAIR_LEN localparam is derived in-module.
- One natural sub-module: mux_key_internal. It is the purely combinational compare/priority/select core, with parameters NR_KEY, KEY_LEN, DATA_LEN, HAS_DEFAULT.
  - The top adds default selection and the async-reset output register.
  - mux_key_internal is reusable by a future no-default variant.

Test Plan:
- Read-port select. Config NR_KEY=2, KEY_LEN=1, DATA_LEN=32; lut={1'b0,32'h0,1'b1,32'hDEADBEEF}; default_out=32'h0.
  - key=1 -> out=32'hDEADBEEF, hit=1.
  - key=0 -> out=32'h0, hit=1.
  - After the next clk edge: out_q and hit_q equal the prior-cycle out and hit.
- Default path. Config NR_KEY=3, KEY_LEN=2, DATA_LEN=8; keys 2'b00/2'b01/2'b10 with data 8'h11/8'h22/8'h33; default_out=8'hA5.
  - key=2'b11 -> out=8'hA5, hit=0.
  - key=2'b10 -> out=8'h33, hit=1.
- Priority. Same config with pair 0 and pair 2 both keyed 2'b01, data 8'h11 and 8'h77.
  - key=2'b01 -> out=8'h11, because the lowest index wins.
- Asynchronous reset.
  - With out_q=8'h33, assert rst_n=0 between clock edges -> out_q=0 and hit_q=0 immediately, while out still shows 8'h33.
  - Deassert rst_n -> out_q=8'h33 after the first rising edge.
- Combinational tracking. Change default_out from 8'hA5 to 8'h5A with a non-matching key -> out=8'h5A in the same cycle; out_q updates after one edge.
- Randomised sweep. 1000 random key/lut/default vectors, checked against a priority-lookup reference model for out, hit, out_q and hit_q.
